// File: rtl/capture_buffer.sv
// capture_buffer: level-triggered multi-channel capture into a RAM ring, streamed out oldest-first.
// Optional CAPTURE_TIMESTAMP_EN adds trig_timestamp (cycles from arm edge to trigger-store edge).
module capture_buffer #(
    parameter int CH_WIDTH = 17,
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 256,
    parameter int DECIM_W  = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_CH*CH_WIDTH-1:0]                   din,
    input  logic                                         din_valid,
    input  logic                                         arm,
    input  logic                                         abort,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] trig_sel,
    input  logic signed [CH_WIDTH-1:0]                   trig_level,
    input  logic                                         trig_rising,
    input  logic [DECIM_W-1:0]                           decim,
    output logic [NUM_CH*CH_WIDTH-1:0]                   rd_data,
    output logic                                         rd_valid,
    input  logic                                         rd_ready,
    output logic                                         rd_last,
    output logic [2:0]                                   state,
    output logic                                         triggered,
    output logic                                         done
`ifdef CAPTURE_TIMESTAMP_EN
    ,output logic [31:0]                                 trig_timestamp
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int W = NUM_CH * CH_WIDTH;
    localparam int TS_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [AW:0] PRE_LAST = (AW+1)'(PRE_TRIG - 1);
    localparam logic [AW:0] POST_LAST = (AW+1)'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PRE_A = AW'(PRE_TRIG);
    localparam bit ONE_POST = (DEPTH - PRE_TRIG) == 1;

    typedef enum logic [2:0] {IDLE = 3'd0, PREFILL = 3'd1, ARMED = 3'd2, POST = 3'd3, READ = 3'd4} st_t;
    st_t st;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] ram_q, sk_data;
    logic [AW-1:0] wr_ptr, rd_addr;
    logic [AW:0] cnt, rd_left;
    logic [DECIM_W-1:0] dcnt;
    logic signed [CH_WIDTH-1:0] prev, cur;
    logic [TS_W-1:0] sel;
    logic have_prev, q_v, q_last, sk_valid, sk_last;
    logic capturing, store, hit, xfer, issue;
    logic [1:0] occ;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] cyc;
`endif

    assign state = st;
    assign sel = 32'(trig_sel) < NUM_CH ? trig_sel : '0;
    assign cur = din[32'(sel)*CH_WIDTH +: CH_WIDTH];
    assign capturing = st == PREFILL || st == ARMED || st == POST;
    assign store = capturing && din_valid && dcnt == '0;
    assign hit = store && st == ARMED && have_prev &&
                 (trig_rising ? (prev < trig_level && cur >= trig_level)
                              : (prev > trig_level && cur <= trig_level));
    assign xfer = rd_valid && rd_ready;
    // items that will sit in output/skid/RAM-latch after this edge; a new read needs one free slot
    assign occ = 2'(rd_valid) + 2'(sk_valid) + 2'(q_v) - 2'(xfer);
    assign issue = st == READ && rd_left != '0 && occ <= 2'd1;

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= din;
        if (issue) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            st <= IDLE;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            sk_valid <= 1'b0;
            q_v <= 1'b0;
            done <= 1'b0;
            triggered <= 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
            trig_timestamp <= '0;
`endif
            if (reset) begin
                rd_data <= '0;
                wr_ptr <= '0;
                rd_addr <= '0;
                cnt <= '0;
                rd_left <= '0;
                dcnt <= '0;
                prev <= '0;
                have_prev <= 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
                cyc <= '0;
`endif
            end
        end else begin
`ifdef CAPTURE_TIMESTAMP_EN
            cyc <= &cyc ? cyc : cyc + 1'b1;
`endif
            if (st == IDLE && arm) begin
                st <= PRE_TRIG == 0 ? ARMED : PREFILL;
                wr_ptr <= '0;
                cnt <= '0;
                dcnt <= '0;
                prev <= '0;
                have_prev <= 1'b0;
                triggered <= 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
                cyc <= 32'd1;
`endif
            end
            if (capturing && din_valid) dcnt <= store ? decim : dcnt - 1'b1;
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                prev <= cur;
                have_prev <= 1'b1;
            end
            if (store && st == PREFILL) begin
                cnt <= cnt == PRE_LAST ? '0 : cnt + 1'b1;
                if (cnt == PRE_LAST) st <= ARMED;
            end
            if (hit) begin
                rd_addr <= wr_ptr - PRE_A;
                rd_left <= FULL;
                cnt <= ONE;
                triggered <= 1'b1;
                done <= ONE_POST;
                st <= ONE_POST ? READ : POST;
`ifdef CAPTURE_TIMESTAMP_EN
                trig_timestamp <= cyc;
`endif
            end
            if (store && st == POST) begin
                cnt <= cnt + 1'b1;
                if (cnt == POST_LAST) begin
                    st <= READ;
                    done <= 1'b1;
                end
            end
            q_v <= issue;
            if (issue) begin
                q_last <= rd_left == ONE;
                rd_addr <= rd_addr + 1'b1;
                rd_left <= rd_left - 1'b1;
            end
            if (!rd_valid || xfer) begin
                rd_valid <= sk_valid || q_v;
                rd_data <= sk_valid ? sk_data : q_v ? ram_q : rd_data;
                rd_last <= sk_valid ? sk_last : q_v && q_last;
                sk_valid <= sk_valid && q_v;
                if (sk_valid) begin
                    sk_data <= ram_q;
                    sk_last <= q_last;
                end
            end else if (q_v) begin
                sk_valid <= 1'b1;
                sk_data <= ram_q;
                sk_last <= q_last;
            end
            if (xfer && rd_last) begin
                st <= IDLE;
                done <= 1'b0;
                triggered <= 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
                trig_timestamp <= '0;
`endif
            end
        end
    end
endmodule

// File: doc/capture_buffer.md
# capture_buffer

Synthesizable multi-channel waveform capture buffer for the DDFS datapath. It records decimated samples of up to NUM_CH signed channels (sine, triangle, PWM taps) into on-chip RAM around a programmable level trigger. Captured samples are then streamed out oldest-first over a valid/ready port. This lets the 10 000-cycle file dumps currently done in simulation be taken on hardware instead.

## Interface
- CH_WIDTH, 17: width of each signed channel sample
- NUM_CH, 2: number of channels captured in parallel
- DEPTH, 1024: samples per capture; power of two, ≥ 4
- PRE_TRIG, 256: samples kept before the trigger sample; 0 ≤ PRE_TRIG < DEPTH
- DECIM_W, 8: width of the decimation control
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- din  in  NUM_CH*CH_WIDTH  flattened samples; channel k at bits [k*CH_WIDTH +: CH_WIDTH]
- din_valid  in  1  din is a new sample this cycle
- arm  in  1  start a capture; honoured only in IDLE
- abort  in  1  abandon a capture or readout; has priority over arm
- trig_sel  in  max(1,$clog2(NUM_CH))  channel compared against the trigger level
- trig_level  in  CH_WIDTH  signed trigger threshold
- trig_rising  in  1  1 selects rising-edge trigger, 0 selects falling-edge trigger
- decim  in  DECIM_W  store one accepted sample, then skip decim accepted samples
- rd_data  out  NUM_CH*CH_WIDTH  readout sample
- rd_valid  out  1  rd_data is valid
- rd_ready  in  1  consumer accepts rd_data
- rd_last  out  1  rd_data is the final (DEPTH-th) sample
- state  out  3  IDLE=0, PREFILL=1, ARMED=2, POST=3, READ=4
- triggered  out  1  trigger seen in the current capture
- done  out  1  capture complete; readout in progress

## Operation
- **Storage rule.** Stores happen only in PREFILL, ARMED and POST. A sample is stored when din_valid=1 and the decimation counter is 0. The counter reloads to decim on each store and decrements on each unstored din_valid. It is cleared on arm, so the first valid sample after arm is always stored.
- **Write pointer.** Wraps modulo DEPTH.
- **Trigger detection.** Compares each stored sample on trig_sel with the previously stored one (prev):
  - rising: prev < trig_level and cur ≥ trig_level
  - falling: prev > trig_level and cur ≤ trig_level
  - All comparisons are signed.
  - The first stored sample after arm has no prev and never triggers.
- **State transitions.**
  - IDLE: arm moves to PREFILL, or directly to ARMED if PRE_TRIG=0. Counters, prev and triggered are cleared.
  - PREFILL: stores samples but detection is disabled; prev still updates. After PRE_TRIG stores, moves to ARMED.
  - ARMED: a detected trigger stores the trigger sample, latches its address, sets triggered=1 and moves to POST.
  - POST: counts stores, with the trigger sample as the first. Once DEPTH−PRE_TRIG samples are stored, moves to READ.
  - READ: done=1. Streams DEPTH samples from address (trig_addr − PRE_TRIG) mod DEPTH, oldest first. rd_last is asserted with the final sample. The handshake on rd_last returns to IDLE and clears done and triggered.
- **Abort.** abort=1 in any state moves to IDLE on the next cycle, with rd_valid=0, done=0 and triggered=0.
- **arm outside IDLE.** Ignored.
- **din_valid outside PREFILL/ARMED/POST.** Ignored.
- **trig_sel ≥ NUM_CH.** Treated as channel 0.

## Timing
- **Reset values.** state=0, rd_valid=0, rd_data=0, rd_last=0, triggered=0, done=0. Pointers, prev and the decimation counter are zeroed. RAM contents are don't-care.
- **Entering PREFILL/ARMED.** Happens on the edge after arm is sampled high.
- **Trigger.** The trigger sample is stored on edge N. state=POST and triggered=1 are visible from cycle N+1.
- **Entering READ.** Happens on the edge that stores the last post-trigger sample.
- **First readout.** rd_valid first rises exactly 2 cycles after state=READ (synchronous RAM read plus output register).
- **Throughput.** With rd_ready held high, one sample is transferred per cycle with no bubbles, using prefetch and a skid register.
- **Backpressure.** While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
- **Handshake.** A transfer occurs on an edge where rd_valid and rd_ready are both high. rd_valid never drops without a transfer, except on abort or reset.
- **Reset or abort mid-readout.** rd_valid=0 on the next cycle; no partial sample appears afterwards.

## Configuration
- **CAPTURE_TIMESTAMP_EN defined:**
  - Adds output trig_timestamp [31:0], the number of clk cycles from the arm edge to the trigger-store edge.
  - Valid while triggered=1; otherwise 0; reset 0.
  - The internal cycle counter saturates at 32'hFFFFFFFF.
- **Undefined:** the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Rising trigger, ramp.** DEPTH=16, PRE_TRIG=4, decim=0, ch0 ramp 0,1,2…, level=100, rising. Required: readout 96..111 in order, rd_last only on 111, then state=0.
- **Decimation.** decim=2, same ramp, level=30. Required: stored values step by 3, trigger at 30, readout 18,21,…,63.
- **Falling trigger on channel 1.** trig_sel=1, falling, level=0, ch1 descending from 50 with ch0 random. Required: the sample at index PRE_TRIG is the first ch1 ≤ 0; ch0 columns are aligned to it.
- **Backpressure.** rd_ready driven with a pseudo-random pattern. Required: exactly 16 transfers, no duplicates or drops, rd_data stable while stalled.
- **Abort and reset.** abort in POST gives state=0 next cycle with no rd_valid. Reset after 5 readout transfers gives rd_valid=0 next cycle; a re-arm captures correctly.
- **Timestamp (CAPTURE_TIMESTAMP_EN).** din_valid every cycle, arm at cycle 0, trigger stored 37 cycles later. Required: trig_timestamp=37.
